// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipe_ctrl_pkg : shared types/constants for the pipeline stall ctrl   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package pipe_ctrl_pkg;

  localparam int REG_ADDR_W = 5;

  typedef enum logic [0:0] {
    RUN       = 1'b0,
    MULT_WAIT = 1'b1
  } state_t;

  typedef struct packed {
    logic en;
    logic flush;
  } stage_ctrl_t;

  // Saturating increment used by the optional performance counters.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic inc);
    return (inc && (v != '1)) ? v + 32'd1 : v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_stall_ctrl_hazard_detect.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hazard_detect : combinational load-use comparator (ID vs EX load)    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module hazard_detect #(
  parameter int REG_ADDR_W = pipe_ctrl_pkg::REG_ADDR_W
) (
  input  logic [REG_ADDR_W-1:0] if_id_rs1,
  input  logic [REG_ADDR_W-1:0] if_id_rs2,
  input  logic                  if_id_uses_rs2,
  input  logic                  id_ex_memread,
  input  logic [REG_ADDR_W-1:0] id_ex_rd,
  output logic                  lu
);

  // x0 is hardwired to zero, so a load targeting it never creates a hazard.
  always_comb begin
    lu = id_ex_memread && (id_ex_rd != '0) &&
         ((id_ex_rd == if_id_rs1) || (if_id_uses_rs2 && (id_ex_rd == if_id_rs2)));
  end

endmodule
`default_nettype wire

// File: rtl/pipe_stall_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipe_stall_ctrl : stall/flush sequencer for the 5-stage pipeline;    |
// | optional perf counters under `PIPE_STALL_PERF_EN. Rev 1.0            |
// +----------------------------------------------------------------------+
module pipe_stall_ctrl #(
  parameter int MULT_LAT   = 2,
  parameter int REG_ADDR_W = pipe_ctrl_pkg::REG_ADDR_W,
  parameter int CNT_W      = 4
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic [REG_ADDR_W-1:0] if_id_rs1,
  input  logic [REG_ADDR_W-1:0] if_id_rs2,
  input  logic                  if_id_uses_rs2,
  input  logic                  id_ex_memread,
  input  logic [REG_ADDR_W-1:0] id_ex_rd,
  input  logic                  ex_mult_start,
  input  logic                  mem_branch_taken,
  output logic                  pc_en,
  output logic                  if_id_en,
  output logic                  id_ex_en,
  output logic                  ex_mem_en,
  output logic                  mem_wb_en,
  output logic                  if_id_flush,
  output logic                  id_ex_flush,
  output logic                  ex_mem_flush,
  output logic                  mult_busy
`ifdef PIPE_STALL_PERF_EN
  ,
  output logic [31:0]           stall_cycles,
  output logic [31:0]           flush_events,
  output logic [31:0]           lu_events
`endif
);

  import pipe_ctrl_pkg::*;

  localparam logic [CNT_W-1:0] CNT_LOAD    = CNT_W'((MULT_LAT > 1) ? (MULT_LAT - 2) : 0);
  localparam logic             MULT_STALLS = (MULT_LAT > 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              lu;
  logic              ms;
  logic              lu_bubble;
  logic              pc_en_c;
  logic              mem_wb_en_c;
  stage_ctrl_t       if_id_c, id_ex_c, ex_mem_c;

  hazard_detect #(
    .REG_ADDR_W(REG_ADDR_W)
  ) u_hazard_detect (
    .if_id_rs1      (if_id_rs1),
    .if_id_rs2      (if_id_rs2),
    .if_id_uses_rs2 (if_id_uses_rs2),
    .id_ex_memread  (id_ex_memread),
    .id_ex_rd       (id_ex_rd),
    .lu             (lu)
  );

  // While waiting, the held multiply's start level is ignored; only cnt matters.
  always_comb begin
    ms = (state_q == RUN) ? (ex_mult_start & MULT_STALLS) : (cnt_q != '0);
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    lu_bubble   = 1'b0;
    pc_en_c     = 1'b1;
    mem_wb_en_c = 1'b1;
    if_id_c     = '{en: 1'b1, flush: 1'b0};
    id_ex_c     = '{en: 1'b1, flush: 1'b0};
    ex_mem_c    = '{en: 1'b1, flush: 1'b0};

    if (mem_branch_taken) begin
      // The multiply (if any) is younger than the branch, so it is squashed too.
      if_id_c.flush  = 1'b1;
      id_ex_c.flush  = 1'b1;
      ex_mem_c.flush = 1'b1;
      state_d        = RUN;
      cnt_d          = '0;
    end else if (ms) begin
      pc_en_c        = 1'b0;
      if_id_c.en     = 1'b0;
      id_ex_c.en     = 1'b0;
      ex_mem_c.flush = 1'b1;
      if (state_q == RUN) begin
        state_d = MULT_WAIT;
        cnt_d   = CNT_LOAD;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end else begin
      state_d = RUN;
      if (lu) begin
        pc_en_c       = 1'b0;
        if_id_c.en    = 1'b0;
        id_ex_c.flush = 1'b1;
        lu_bubble     = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs are forced low for the whole time reset is asserted.
  assign pc_en        = arst_n & pc_en_c;
  assign if_id_en     = arst_n & if_id_c.en;
  assign id_ex_en     = arst_n & id_ex_c.en;
  assign ex_mem_en    = arst_n & ex_mem_c.en;
  assign mem_wb_en    = arst_n & mem_wb_en_c;
  assign if_id_flush  = arst_n & if_id_c.flush;
  assign id_ex_flush  = arst_n & id_ex_c.flush;
  assign ex_mem_flush = arst_n & ex_mem_c.flush;
  assign mult_busy    = arst_n & (state_q == MULT_WAIT);

`ifdef PIPE_STALL_PERF_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [31:0] flush_events_q, flush_events_d;
  logic [31:0] lu_events_q, lu_events_d;

  always_comb begin
    stall_cycles_d = sat_inc(stall_cycles_q, !pc_en_c);
    flush_events_d = sat_inc(flush_events_q, mem_branch_taken);
    lu_events_d    = sat_inc(lu_events_q, lu_bubble);
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      stall_cycles_q <= '0;
      flush_events_q <= '0;
      lu_events_q    <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_events_q <= flush_events_d;
      lu_events_q    <= lu_events_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_events = flush_events_q;
  assign lu_events    = lu_events_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_stall_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_pipe_stall_ctrl : bench for pipe_stall_ctrl at MULT_LAT 2 and 4   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_pipe_stall_ctrl;

  logic       clk = 1'b0;
  logic       arst_n = 1'b0;
  logic [4:0] rs1, rs2, rd;
  logic       use2, memread, mstart, br;

  // {pc, if_id, id_ex, ex_mem, mem_wb, if_id_fl, id_ex_fl, ex_mem_fl, busy}
  wire  [8:0] d2, d4;
  logic [8:0] s2, s4;

  int n_vec = 0;
  int n_err = 0;
  int rem2 = 0;
  int rem4 = 0;
  int st2 = 0;
  int st4 = 0;

`ifdef PIPE_STALL_PERF_EN
  wire  [31:0] sc2, fe2, le2, sc4, fe4, le4;
  logic [31:0] m_sc2 = 0, m_fe2 = 0, m_le2 = 0, m_sc4 = 0, m_fe4 = 0, m_le4 = 0;
`endif

  always #5 clk = ~clk;

  pipe_stall_ctrl #(.MULT_LAT(2), .REG_ADDR_W(5), .CNT_W(4)) u_dut2 (
    .clk(clk), .arst_n(arst_n),
    .if_id_rs1(rs1), .if_id_rs2(rs2), .if_id_uses_rs2(use2),
    .id_ex_memread(memread), .id_ex_rd(rd),
    .ex_mult_start(mstart), .mem_branch_taken(br),
    .pc_en(d2[8]), .if_id_en(d2[7]), .id_ex_en(d2[6]), .ex_mem_en(d2[5]), .mem_wb_en(d2[4]),
    .if_id_flush(d2[3]), .id_ex_flush(d2[2]), .ex_mem_flush(d2[1]), .mult_busy(d2[0])
`ifdef PIPE_STALL_PERF_EN
    , .stall_cycles(sc2), .flush_events(fe2), .lu_events(le2)
`endif
  );

  pipe_stall_ctrl #(.MULT_LAT(4), .REG_ADDR_W(5), .CNT_W(4)) u_dut4 (
    .clk(clk), .arst_n(arst_n),
    .if_id_rs1(rs1), .if_id_rs2(rs2), .if_id_uses_rs2(use2),
    .id_ex_memread(memread), .id_ex_rd(rd),
    .ex_mult_start(mstart), .mem_branch_taken(br),
    .pc_en(d4[8]), .if_id_en(d4[7]), .id_ex_en(d4[6]), .ex_mem_en(d4[5]), .mem_wb_en(d4[4]),
    .if_id_flush(d4[3]), .id_ex_flush(d4[2]), .ex_mem_flush(d4[1]), .mult_busy(d4[0])
`ifdef PIPE_STALL_PERF_EN
    , .stall_cycles(sc4), .flush_events(fe4), .lu_events(le4)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: rem = EX cycles the multiply still occupies, counting the current one.
  function automatic logic [8:0] model_out(input int lat, input int rem,
                                           output int rem_n, output bit lu_b);
    bit lu, busy, ms;
    logic [8:0] o;
    lu   = memread && (rd != 0) && ((rd == rs1) || (use2 && (rd == rs2)));
    busy = (rem > 0);
    ms   = busy ? (rem > 1) : (mstart && (lat > 1));
    lu_b = 1'b0;
    if (br) begin
      o = {8'b11111_111, busy};
      rem_n = 0;
    end else if (ms) begin
      o = {8'b00011_001, busy};
      rem_n = busy ? rem - 1 : lat - 1;
    end else begin
      rem_n = 0;
      if (lu) begin
        o = {8'b00111_010, busy};
        lu_b = 1'b1;
      end else begin
        o = {8'b11111_000, busy};
      end
    end
    return o;
  endfunction

  // Called at posedge+1 with inputs already set; returns at the next posedge+1.
  task automatic step();
    logic [8:0] e2, e4;
    int r2n, r4n;
    bit lb2, lb4;
    #3;
    e2 = model_out(2, rem2, r2n, lb2);
    e4 = model_out(4, rem4, r4n, lb4);
    s2 = d2;
    s4 = d4;
    check_eq("lat2_ctrl", 32'(d2), 32'(e2));
    check_eq("lat4_ctrl", 32'(d4), 32'(e4));
    if (!d2[8]) st2++;
    if (!d4[8]) st4++;
    @(posedge clk);
    rem2 = r2n;
    rem4 = r4n;
`ifdef PIPE_STALL_PERF_EN
    if (!e2[8]) m_sc2++;
    if (!e4[8]) m_sc4++;
    if (br) begin m_fe2++; m_fe4++; end
    if (lb2) m_le2++;
    if (lb4) m_le4++;
`endif
    #1;
  endtask

  task automatic set_in(input logic [4:0] a1, input logic [4:0] a2, input logic u2,
                        input logic mr, input logic [4:0] d, input logic ms_i, input logic b);
    rs1 = a1; rs2 = a2; use2 = u2; memread = mr; rd = d; mstart = ms_i; br = b;
  endtask

  task automatic idle();
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  initial begin
    idle();
    #2;
    check_eq("reset_out2", 32'(d2), 32'd0);
    check_eq("reset_out4", 32'(d4), 32'd0);
    #1 arst_n = 1'b1;
    @(posedge clk); #1;

    // load-use on rs1, then recovery
    set_in(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0); step();
    check_eq("lu_pc_en", 32'(s4[8]), 32'd0);
    idle(); step();
    // load-use via rs2, then rs2 match ignored when unused
    set_in(5'd1, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0); step();
    set_in(5'd1, 5'd7, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0); step();
    // load to x0 never stalls
    set_in(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0); step();
    check_eq("x0_pc_en", 32'(s2[8]), 32'd1);

    // multiply occupancy: 1 stall cycle at lat 2, 3 at lat 4
    idle(); st2 = 0; st4 = 0;
    mstart = 1'b1; step();
    mstart = 1'b0;
    for (int i = 0; i < 5; i++) step();
    check_eq("mul_stalls_lat2", 32'(st2), 32'd1);
    check_eq("mul_stalls_lat4", 32'(st4), 32'd3);

    // branch in the 2nd MULT_WAIT cycle of the lat-4 multiply
    mstart = 1'b1; step();
    mstart = 1'b0; step();
    br = 1'b1; step();
    check_eq("br_mw_flushes", 32'(s4[3:1]), 32'h7);
    br = 1'b0; step();
    check_eq("br_mw_busy_after", 32'(s4[0]), 32'd0);

    // branch and load-use together: flush only
    set_in(5'd3, 5'd0, 1'b0, 1'b1, 5'd3, 1'b0, 1'b1); step();
    check_eq("br_lu_pc_en", 32'(s2[8]), 32'd1);
    idle(); step();

    // asynchronous reset in the middle of MULT_WAIT
    mstart = 1'b1; step();
    mstart = 1'b0; step();
    #1 arst_n = 1'b0;
    #1;
    check_eq("midreset_out2", 32'(d2), 32'd0);
    check_eq("midreset_out4", 32'(d4), 32'd0);
    rem2 = 0; rem4 = 0;
`ifdef PIPE_STALL_PERF_EN
    check_eq("rst_stall_cycles", sc4, 32'd0);
    check_eq("rst_flush_events", fe4, 32'd0);
    check_eq("rst_lu_events", le2, 32'd0);
    m_sc2 = 0; m_fe2 = 0; m_le2 = 0; m_sc4 = 0; m_fe4 = 0; m_le4 = 0;
`endif
    #1 arst_n = 1'b1;
    @(posedge clk); #1;
    idle(); step();
    check_eq("post_reset_en", 32'(s4[8:4]), 32'h1f);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rs1     = 5'($urandom_range(0, 3));
      rs2     = 5'($urandom_range(0, 3));
      rd      = 5'($urandom_range(0, 3));
      use2    = 1'($urandom_range(0, 1));
      memread = ($urandom_range(0, 2) == 0);
      mstart  = ($urandom_range(0, 3) == 0);
      br      = ($urandom_range(0, 7) == 0);
      step();
    end

`ifdef PIPE_STALL_PERF_EN
    check_eq("stall_cycles2", sc2, m_sc2);
    check_eq("flush_events2", fe2, m_fe2);
    check_eq("lu_events2", le2, m_le2);
    check_eq("stall_cycles4", sc4, m_sc4);
    check_eq("flush_events4", fe4, m_fe4);
    check_eq("lu_events4", le4, m_le4);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
